// File: rtl/prbs_checker_8bit_pkg.sv
// Shared definitions for the 8-bit PRBS generator/checker pair.
// The generator and the checker both take the taps, the feedback
// polarity and the next-bit function from here, so the two ends of
// the link always agree on the sequence.
package prbs_checker_8bit_pkg;

  // Window tap positions. Index 0 is the newest bit, index i is the
  // bit received i bits earlier.
  localparam int TAP_A = 7;
  localparam int TAP_B = 5;
  localparam int TAP_C = 4;
  localparam int TAP_D = 3;

  // XNOR feedback: the all-ones window maps onto itself (lock-up state).
  localparam logic XNOR_POL = 1'b1;

  // Checker state encoding.
  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_FILL   = 2'd1,
    ST_CHECK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  // Predicted next bit for an 8-bit history window.
  function automatic logic prbs_next(input logic [7:0] win);
    return win[TAP_A] ^ win[TAP_B] ^ win[TAP_C] ^ win[TAP_D] ^ XNOR_POL;
  endfunction

endpackage

// File: rtl/prbs_checker_8bit_if.sv
// Signal bundle between the serial link / status consumer and the
// PRBS checker.
//
// Handshake: bit_valid is a one-cycle qualifier with no ready and no
// backpressure. A consumer must capture bit_error (and may capture
// locked / stuck_ones) in the cycle bit_valid is high; bit_error is
// only ever high together with bit_valid. locked, stuck_ones,
// err_count and dbg_state are plain levels, valid in every cycle.
interface prbs_checker_8bit_if;
  import prbs_checker_8bit_pkg::*;

  logic        signal_in;
  logic        clear_counts;
  logic        bit_valid;
  logic        bit_error;
  logic        locked;
  logic        stuck_ones;
  logic [15:0] err_count;
  state_t      dbg_state;

  // Link side: drives the serial stream and the count clear.
  modport master (
    output signal_in,
    output clear_counts,
    input  bit_valid,
    input  bit_error,
    input  locked,
    input  stuck_ones,
    input  err_count,
    input  dbg_state
  );

  // Checker side.
  modport slave (
    input  signal_in,
    input  clear_counts,
    output bit_valid,
    output bit_error,
    output locked,
    output stuck_ones,
    output err_count,
    output dbg_state
  );

endinterface

// File: rtl/prbs_checker_8bit_bit_sampler.sv
// Bit-timing recovery: registers the serial input, detects edges,
// runs the bit-phase counter and raises a mid-bit sample strobe.
module prbs_checker_8bit_bit_sampler #(
  parameter int BIT_PERIOD = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic signal_i,
  input  logic active_i,
  output logic sig_o,
  output logic edge_o,
  output logic sample_o
);

  localparam int PW = (BIT_PERIOD > 2) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [PW-1:0] PH_LAST   = PW'(BIT_PERIOD - 1);
  localparam logic [PW-1:0] PH_SAMPLE = PW'(BIT_PERIOD / 2 - 1);

  logic          sig_q, sig_d;
  logic          primed_q, primed_d;
  logic [PW-1:0] phase_q, phase_d;
  logic          edge_det;

  // Edge detect and phase counter. sig_q holds its reset value for the
  // first cycle after reset, so edge detection waits one cycle; a line
  // that simply sits high out of reset is not mistaken for an edge.
  always_comb begin
    sig_d    = signal_i;
    primed_d = 1'b1;
    edge_det = primed_q && (signal_i != sig_q);
    if (edge_det || (phase_q == PH_LAST)) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + 1'b1;
    end
  end

  // Timing registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sig_q    <= 1'b0;
      primed_q <= 1'b0;
      phase_q  <= '0;
    end else begin
      sig_q    <= sig_d;
      primed_q <= primed_d;
      phase_q  <= phase_d;
    end
  end

  assign sig_o    = sig_q;
  assign edge_o   = edge_det;
  // Mid-bit strobe; an edge landing mid-bit only re-aligns phase_q and
  // never produces a second strobe for the same bit.
  assign sample_o = active_i && (phase_q == PH_SAMPLE);

endmodule

// File: rtl/prbs_checker_8bit.sv
// Receive-side PRBS checker: self-synchronises an 8-bit predictor to
// the incoming sequence, then checks every bit, reporting lock,
// per-bit errors and a saturating error count.
module prbs_checker_8bit
  import prbs_checker_8bit_pkg::*;
#(
  parameter int BIT_PERIOD  = 100,
  parameter int LOCK_COUNT  = 16,
  parameter int UNLOCK_ERRS = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  prbs_checker_8bit_if.slave bus
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam int UW = $clog2(UNLOCK_ERRS + 1);
  localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_COUNT - 1);
  localparam logic [UW-1:0] MISS_LAST  = UW'(UNLOCK_ERRS - 1);

  state_t        state_q, state_d;
  logic [7:0]    rx_q, rx_d;
  logic [2:0]    fill_q, fill_d;
  logic [MW-1:0] match_q, match_d;
  logic [UW-1:0] miss_q, miss_d;
  logic [15:0]   err_q, err_d;
  logic          bit_valid_q, bit_valid_d;
  logic          bit_error_q, bit_error_d;
  logic          locked_q, locked_d;
  logic          stuck_q, stuck_d;

  logic samp_bit;
  logic samp_edge;
  logic sample;
  logic pred;
  logic mismatch;

  prbs_checker_8bit_bit_sampler #(
    .BIT_PERIOD(BIT_PERIOD)
  ) u_bit_sampler (
    .clk      (clk),
    .reset_n  (reset_n),
    .signal_i (bus.signal_in),
    .active_i (state_q != ST_HUNT),
    .sig_o    (samp_bit),
    .edge_o   (samp_edge),
    .sample_o (sample)
  );

  assign pred     = prbs_next(rx_q);
  assign mismatch = (samp_bit != pred);

  // Next-state logic: synchronisation FSM, predictor window, counters.
  always_comb begin
    state_d     = state_q;
    rx_d        = rx_q;
    fill_d      = fill_q;
    match_d     = match_q;
    miss_d      = miss_q;
    err_d       = err_q;
    bit_error_d = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (samp_edge) begin
          state_d = ST_FILL;
          fill_d  = '0;
        end
      end

      ST_FILL: begin
        if (sample) begin
          rx_d = {rx_q[6:0], samp_bit};
          if (fill_q == 3'd7) begin
            state_d = ST_CHECK;
            match_d = '0;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
      end

      ST_CHECK: begin
        if (sample) begin
          rx_d = {rx_q[6:0], samp_bit};
          if (!mismatch) begin
            if (match_q == MATCH_LAST) begin
              state_d = ST_LOCKED;
              miss_d  = '0;
            end else begin
              match_d = match_q + 1'b1;
            end
          end else begin
            state_d = ST_FILL;
            fill_d  = '0;
          end
        end
      end

      ST_LOCKED: begin
        if (sample) begin
          // Feed the prediction back so a bad bit cannot corrupt later
          // predictions.
          rx_d = {rx_q[6:0], pred};
          if (mismatch) begin
            bit_error_d = 1'b1;
            if (err_q != 16'hFFFF) begin
              err_d = err_q + 1'b1;
            end
            if (miss_q == MISS_LAST) begin
              state_d = ST_FILL;
              fill_d  = '0;
            end else begin
              miss_d = miss_q + 1'b1;
            end
          end else begin
            miss_d = '0;
          end
        end
      end

      default: state_d = ST_HUNT;
    endcase

    // Clear wins over a same-cycle increment.
    if (bus.clear_counts) begin
      err_d = '0;
    end

    bit_valid_d = sample;
    locked_d    = (state_d == ST_LOCKED);
    stuck_d     = (state_d != ST_HUNT) && (rx_d == 8'hFF);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_HUNT;
      rx_q        <= '0;
      fill_q      <= '0;
      match_q     <= '0;
      miss_q      <= '0;
      err_q       <= '0;
      bit_valid_q <= 1'b0;
      bit_error_q <= 1'b0;
      locked_q    <= 1'b0;
      stuck_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_q        <= rx_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      err_q       <= err_d;
      bit_valid_q <= bit_valid_d;
      bit_error_q <= bit_error_d;
      locked_q    <= locked_d;
      stuck_q     <= stuck_d;
    end
  end

  assign bus.bit_valid  = bit_valid_q;
  assign bus.bit_error  = bit_error_q;
  assign bus.locked     = locked_q;
  assign bus.stuck_ones = stuck_q;
  assign bus.err_count  = err_q;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_prbs_checker_8bit.sv
// Bench for prbs_checker_8bit: a PRBS generator model drives the serial
// line; each driven bit pushes its expected {bit_error, locked,
// stuck_ones} into a queue that a monitor pops on every bit_valid.
module tb_prbs_checker_8bit;
  import prbs_checker_8bit_pkg::*;

  localparam int BP   = 8;
  localparam int HALF = BP / 2;
  localparam int LC   = 16;
  localparam int UE   = 4;

  // ---------------- clock / reset ----------------
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  prbs_checker_8bit_if bus();

  prbs_checker_8bit #(
    .BIT_PERIOD (BP),
    .LOCK_COUNT (LC),
    .UNLOCK_ERRS(UE)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // ---------------- scoreboard state ----------------
  int         checks     = 0;
  int         errors     = 0;
  int         valid_seen = 0;
  logic [2:0] exp_q[$];
  logic [2:0] mon_e;
  logic [7:0] gen_win;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Generator model: XNOR of taps 7,5,4,3, newest bit at index 0.
  task automatic gen_next(output logic b);
    b       = ~(gen_win[7] ^ gen_win[5] ^ gen_win[4] ^ gen_win[3]);
    gen_win = {gen_win[6:0], b};
  endtask

  // Holds one bit for BP clocks; optionally raises clear_counts exactly
  // in the sample cycle of this bit. Entered just after a rising edge.
  task automatic drive_bit(input logic b, input logic clr);
    bus.signal_in = b;
    for (int i = 0; i < BP; i++) begin
      @(posedge clk);
      #1;
      bus.clear_counts = clr && (i == HALF - 1);
    end
  endtask

  task automatic send(input logic inv, input logic e_err, input logic e_lock,
                      input logic e_stuck, input logic clr);
    logic b;
    gen_next(b);
    exp_q.push_back({e_err, e_lock, e_stuck});
    drive_bit(b ^ inv, clr);
  endtask

  task automatic do_reset();
    reset_n          = 1'b0;
    bus.signal_in    = 1'b0;
    bus.clear_counts = 1'b0;
    gen_win          = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic lock_up();
    for (int k = 1; k <= 8 + LC; k++) begin
      send(1'b0, 1'b0, (k >= 8 + LC), 1'b0, 1'b0);
    end
    check("locked_after_24_bits", 32'(bus.locked), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"},    32'(bus.locked),     32'd0);
    check({tag, "_bit_valid"}, 32'(bus.bit_valid),  32'd0);
    check({tag, "_bit_error"}, 32'(bus.bit_error),  32'd0);
    check({tag, "_stuck"},     32'(bus.stuck_ones), 32'd0);
    check({tag, "_err_count"}, 32'(bus.err_count),  32'd0);
    check({tag, "_state"},     32'(bus.dbg_state),  32'(ST_HUNT));
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (bus.bit_valid) begin
          valid_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_bit_valid", 32'(bus.bit_valid), 32'd0);
          end else begin
            mon_e = exp_q.pop_front();
            check("sample_err_lock_stuck",
                  32'({bus.bit_error, bus.locked, bus.stuck_ones}), 32'(mon_e));
          end
        end else if (bus.bit_error) begin
          check("bit_error_without_valid", 32'(bus.bit_error), 32'd0);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.signal_in    = 1'b1;
    bus.clear_counts = 1'b0;
    gen_win          = 8'h01;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // Line held high from reset: no edge, so the checker never leaves HUNT.
    reset_n = 1'b1;
    repeat (40 * BP) @(posedge clk);
    #1;
    check("const_high_valid_count", 32'(valid_seen), 32'd0);
    check("const_high_state",       32'(bus.dbg_state), 32'(ST_HUNT));
    check("const_high_locked",      32'(bus.locked), 32'd0);

    // One edge then all ones: window fills to 8'hFF (lock-up state).
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      exp_q.push_back({1'b0, 1'b0, (k >= 8)});
      drive_bit(1'b1, 1'b0);
    end
    check("all_ones_stuck_level", 32'(bus.stuck_ones), 32'd1);

    // Clean lock from seed 8'h01, then a long clean run.
    do_reset();
    lock_up();
    for (int k = 0; k < 1000; k++) send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clean_run_err_count", 32'(bus.err_count), 32'd0);

    // Single inverted bit: one error, lock held, later bits clean.
    send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("single_err_count",  32'(bus.err_count), 32'd1);
    check("single_err_locked", 32'(bus.locked), 32'd1);

    // Clear on a clean bit, then four inverted bits drop lock.
    send(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check("clear_counts", 32'(bus.err_count), 32'd0);
    for (int k = 0; k < UE - 1; k++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("unlock_err_count", 32'(bus.err_count), 32'd4);
    check("unlock_locked",    32'(bus.locked), 32'd0);
    for (int k = 1; k < 8 + LC; k++) send(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("relock_locked", 32'(bus.locked), 32'd1);
    for (int k = 0; k < 10; k++) send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Saturation: preload 16'hFFFE early in a clean bit, then 3 errors.
    fork
      send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      begin
        #2;
        force dut.err_q = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.err_q;
      end
    join
    check("sat_preload", 32'(bus.err_count), 32'hFFFE);
    for (int k = 0; k < 3; k++) send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("sat_hold", 32'(bus.err_count), 32'hFFFF);
    send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    check("clear_beats_error", 32'(bus.err_count), 32'd0);
    for (int k = 0; k < 5; k++) send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset while locked, then relock from scratch.
    send(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_reset_err_count", 32'(bus.err_count), 32'd1);
    check("pre_reset_locked",    32'(bus.locked), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    do_reset();
    lock_up();
    for (int k = 0; k < 10; k++) send(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("relock_err_count", 32'(bus.err_count), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
